// File: rtl/scan_7seg_ctrl.sv
// Multiplexed active-low 7-segment scanner: per-frame input snapshot, leading-zero suppression, blanking, PWM dimming.
// Outputs are registered, one cycle behind the counter/snapshot state. There is no backpressure; inputs are sampled once per frame.
module scan_7seg_ctrl #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 1000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   nums,
  input  logic [DIGITS-1:0]     dot_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int SLOT_W = $clog2(DIGITS);
  localparam int PRE_W  = $clog2(REFRESH_DIV);

  logic [PRE_W-1:0]    pre_cnt;
  logic [SLOT_W-1:0]   slot;
  logic [BRIGHT_W-1:0] pwm_cnt;

  logic [4*DIGITS-1:0] nums_q;
  logic [DIGITS-1:0]   dot_q;
  logic [DIGITS-1:0]   blank_q;
  logic                lz_q;
  logic [BRIGHT_W-1:0] bright_q;

  logic                pre_wrap;
  logic                load;

  assign pre_wrap = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
  assign load     = (slot == '0) && (pre_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      slot    <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pre_wrap) begin
        pre_cnt <= '0;
        slot    <= (slot == SLOT_W'(DIGITS - 1)) ? '0 : slot + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // Frame buffer: loads on the dark guard cycle of slot 0, so a frame is never torn.
  always_ff @(posedge clk) begin
    if (reset) begin
      nums_q   <= '0;
      dot_q    <= '0;
      blank_q  <= '0;
      lz_q     <= 1'b0;
      bright_q <= '0;
    end else if (load) begin
      nums_q   <= nums;
      dot_q    <= dot_in;
      blank_q  <= blank_in;
      lz_q     <= lz_en;
      bright_q <= brightness;
    end
  end

  // zero_from[k]: digit k and every digit above it are zero
  logic [DIGITS-1:0] zero_from;
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (nums_q[4*(DIGITS-1) +: 4] == 4'h0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (nums_q[4*k +: 4] == 4'h0);
    end
  end

  logic [3:0]        cur_dig;
  logic              cur_dot;
  logic              cur_blank;
  logic              cur_supp;
  logic [DIGITS-1:0] an_sel;
  logic              lit;

  always_comb begin
    cur_dig   = '0;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    an_sel    = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (slot == SLOT_W'(k)) begin
        cur_dig   = nums_q[4*k +: 4];
        cur_dot   = dot_q[k];
        cur_blank = blank_q[k];
        cur_supp  = lz_q && (k != 0) && zero_from[k];
        an_sel[k] = 1'b0;
      end
    end
  end

  assign lit = !cur_blank && !cur_supp && (pre_cnt != '0) && (pwm_cnt <= bright_q);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= load;
      if (lit) begin
        an  <= an_sel;
        seg <= decode(cur_dig);
        dp  <= ~cur_dot;
      end else begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_7seg_ctrl.sv
// Bench for scan_7seg_ctrl (4 digits, 4-cycle slots, 2-bit brightness): cycle model plus directed literal checks.
module tb_scan_7seg_ctrl;
  localparam int D  = 4;
  localparam int RD = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4*D-1:0] nums = '0;
  logic [D-1:0]  dot_in = '0;
  logic [D-1:0]  blank_in = '0;
  logic          lz_en = 1'b0;
  logic [BW-1:0] brightness = '0;
  logic [6:0]    seg;
  logic [D-1:0]  an;
  logic          dp;
  logic          frame_tick;

  int checks = 0;
  int errors = 0;

  scan_7seg_ctrl #(.DIGITS(D), .REFRESH_DIV(RD), .BRIGHT_W(BW)) dut (
    .clk(clk), .reset(reset), .nums(nums), .dot_in(dot_in), .blank_in(blank_in),
    .lz_en(lz_en), .brightness(brightness), .seg(seg), .an(an), .dp(dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: n counts clock edges since reset release; everything derives from it.
  int             n = 0;
  logic           mvalid = 1'b0;
  logic [4*D-1:0] m_nums;
  logic [D-1:0]   m_dot, m_blank;
  logic           m_lz;
  int             m_bright;
  logic [D-1:0]   exp_an;
  logic [6:0]     exp_seg;
  logic           exp_dp, exp_tick;

  always @(posedge clk) begin
    int pre, slot, pwm, msd, dig;
    logic lit;
    if (reset) begin
      n = 0;
      m_nums = '0; m_dot = '0; m_blank = '0; m_lz = 1'b0; m_bright = 0;
      exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1; exp_tick = 1'b0;
      mvalid = 1'b1;
    end else begin
      pre  = n % RD;
      slot = (n / RD) % D;
      pwm  = n % (1 << BW);
      msd  = 0;
      for (int k = 0; k < D; k++) if (m_nums[4*k +: 4] != 4'h0) msd = k;
      dig  = int'(m_nums[4*slot +: 4]);
      lit  = !m_blank[slot] && !(m_lz && slot > msd) && pre != 0 && pwm <= m_bright;
      if (lit) begin
        exp_an = '1;
        exp_an[slot] = 1'b0;
        exp_seg = seg_tab[dig];
        exp_dp = !m_dot[slot];
      end else begin
        exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
      exp_tick = (n % (RD * D) == 0);
      if (exp_tick) begin
        m_nums = nums; m_dot = dot_in; m_blank = blank_in; m_lz = lz_en;
        m_bright = int'(brightness);
      end
      n = n + 1;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL model n=%0d: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                 n, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_tick);
      end
    end
  end

  task automatic expect_out(input string nm, input logic [D-1:0] a, input logic [6:0] s,
                            input logic d, input logic t);
    checks++;
    if (an !== a || seg !== s || dp !== d || frame_tick !== t) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
               nm, an, seg, dp, frame_tick, a, s, d, t);
    end
  endtask

  // Wait until the outputs produced by edge e are visible (sampled on a falling edge).
  task automatic go_to(input int e);
    int guard = 0;
    while (n != e + 1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (n != e + 1) begin
      errors++;
      $display("FAIL go_to: reached n=%0d, wanted %0d", n, e + 1);
    end
  endtask

  task automatic count_frame(input string nm, input int want, input logic use_lit);
    int dcnt = 0;
    int mcnt = 0;
    for (int i = 0; i < RD * D; i++) begin
      @(negedge clk);
      if (an !== 4'hF) dcnt++;
      if (exp_an !== 4'hF) mcnt++;
    end
    checks++;
    if (dcnt != (use_lit ? want : mcnt)) begin
      errors++;
      $display("FAIL %s: active cycles got %0d, want %0d", nm, dcnt, use_lit ? want : mcnt);
    end
  endtask

  initial begin
    nums = 16'h1234; brightness = 2'd3; lz_en = 1'b0; dot_in = 4'b0010; blank_in = '0;
    @(negedge clk);
    expect_out("reset_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    expect_out("reset_hold3", 4'hF, 7'h7F, 1'b1, 1'b0);
    reset = 1'b0;

    go_to(0);  expect_out("first_tick", 4'hF, 7'h7F, 1'b1, 1'b1);
    go_to(1);  expect_out("slot0_4", 4'b1110, 7'h19, 1'b1, 1'b0);
    go_to(4);  expect_out("slot1_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
    go_to(5);  expect_out("slot1_3_dot", 4'b1101, 7'h30, 1'b0, 1'b0);
    go_to(9);  expect_out("slot2_2", 4'b1011, 7'h24, 1'b1, 1'b0);
    go_to(13); expect_out("slot3_1", 4'b0111, 7'h79, 1'b1, 1'b0);
    go_to(16); expect_out("second_tick", 4'hF, 7'h7F, 1'b1, 1'b1);

    go_to(24); nums = 16'hABCD;
    go_to(25); expect_out("midframe_slot2", 4'b1011, 7'h24, 1'b1, 1'b0);
    go_to(29); expect_out("midframe_slot3", 4'b0111, 7'h79, 1'b1, 1'b0);
    go_to(32); expect_out("third_tick", 4'hF, 7'h7F, 1'b1, 1'b1);
    go_to(33); expect_out("abcd_D", 4'b1110, 7'h21, 1'b1, 1'b0);
    go_to(37); expect_out("abcd_C", 4'b1101, 7'h46, 1'b0, 1'b0);
    go_to(41); expect_out("abcd_b", 4'b1011, 7'h03, 1'b1, 1'b0);
    go_to(45); expect_out("abcd_A", 4'b0111, 7'h08, 1'b1, 1'b0);

    lz_en = 1'b1; nums = 16'h0040;
    go_to(49); expect_out("lz_slot0", 4'b1110, 7'h40, 1'b1, 1'b0);
    go_to(53); expect_out("lz_slot1", 4'b1101, 7'h19, 1'b0, 1'b0);
    go_to(57); expect_out("lz_slot2_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
    go_to(61); expect_out("lz_slot3_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
    nums = 16'h0000;
    go_to(65); expect_out("lz_zero_slot0", 4'b1110, 7'h40, 1'b1, 1'b0);
    go_to(69); expect_out("lz_zero_slot1", 4'hF, 7'h7F, 1'b1, 1'b0);

    nums = 16'h8888; lz_en = 1'b0; dot_in = '0; brightness = 2'd0;
    go_to(79);
    count_frame("bright0_model", 0, 1'b0);
    brightness = 2'd1;
    go_to(95); expect_out("bright0_literal_end", 4'hF, 7'h7F, 1'b1, 1'b0);
    count_frame("bright1_count", 4, 1'b1);

    nums = 16'h1234; blank_in = 4'b0100; dot_in = 4'hF; brightness = 2'd3;
    go_to(113); expect_out("blank_slot0", 4'b1110, 7'h19, 1'b0, 1'b0);
    go_to(121); expect_out("blank_slot2", 4'hF, 7'h7F, 1'b1, 1'b0);
    go_to(125); expect_out("blank_slot3", 4'b0111, 7'h79, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    expect_out("midreset", 4'hF, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    go_to(0); expect_out("restart_tick", 4'hF, 7'h7F, 1'b1, 1'b1);
    go_to(1); expect_out("restart_slot0", 4'b1110, 7'h19, 1'b0, 1'b0);
    go_to(5); expect_out("restart_slot1", 4'b1101, 7'h30, 1'b0, 1'b0);
    go_to(9); expect_out("restart_slot2_blank", 4'hF, 7'h7F, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
